// File: rtl/sector_buf_pkg.sv
// Shared types and widths for the sector buffer Avalon-MM slave.
package sector_buf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

endpackage

// File: rtl/sector_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module sector_ram
    import sector_buf_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk_sys,
    input  logic              rd,
    input  logic [BE_W-1:0]   we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents persist across reset, which keeps this mappable to block RAM.
    always_ff @(posedge clk_sys) begin
        for (int k = 0; k < int'(BE_W); k++) begin
            if (we[k]) begin
                mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
        if (rd) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sector_buf_slave.sv
// Avalon-MM burst slave over a sector RAM: FSM, address/beat counters,
// read-valid pipeline and sticky protocol-error flag.
module sector_buf_slave
    import sector_buf_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BURST_W   = 5,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DATA_W-1:0]  avs_writedata,
    input  logic [BE_W-1:0]    avs_byteenable,
    input  logic [BURST_W-1:0] avs_burstcount,
    output logic               avs_waitrequest,
    output logic [DATA_W-1:0]  avs_readdata,
    output logic               avs_readdatavalid,
    output logic               err
);

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [BURST_W-1:0]  rem_q;
    logic [BURST_W-1:0]  len_c;
    logic                over_c;
    logic                idle_ok_c;
    logic                issue_c;
    logic                load_c;
    logic                adv_c;
    logic                err_set_c;
    logic [BE_W-1:0]     we_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [DATA_W-1:0]   ram_q;
    logic                rd_pipe;

    // Burst length: 0 means 1, oversize clamps to MAX_BURST.
    always_comb begin
        over_c = avs_burstcount > BURST_W'(MAX_BURST);
        len_c  = avs_burstcount;
        if (avs_burstcount == '0) begin
            len_c = BURST_W'(1);
        end else if (over_c) begin
            len_c = BURST_W'(MAX_BURST);
        end
    end

    assign idle_ok_c = (state == IDLE) && !avs_waitrequest;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (idle_ok_c) begin
                    if (avs_read) begin
                        next_state = RD;
                    end else if (avs_write && (len_c != BURST_W'(1))) begin
                        next_state = WR;
                    end
                end
            end
            RD:       if (rem_q == '0) next_state = RD_DRAIN;
            RD_DRAIN: if (!rd_pipe) next_state = IDLE;
            WR:       if (avs_write && (rem_q == BURST_W'(1))) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Beat 0 of a read is issued at accept time so data lands two cycles later.
    always_comb begin
        issue_c    = 1'b0;
        load_c     = 1'b0;
        adv_c      = 1'b0;
        err_set_c  = 1'b0;
        we_c       = '0;
        ram_addr_c = addr_q;
        case (state)
            IDLE: begin
                if (idle_ok_c && (avs_read || avs_write)) begin
                    ram_addr_c = avs_address;
                    load_c     = 1'b1;
                    err_set_c  = over_c || (avs_read && avs_write);
                    if (avs_read) begin
                        issue_c = 1'b1;
                    end else begin
                        we_c = avs_byteenable;
                    end
                end
            end
            RD: begin
                if (rem_q != '0) begin
                    issue_c = 1'b1;
                    adv_c   = 1'b1;
                end
            end
            WR: begin
                err_set_c = avs_read;
                if (avs_write) begin
                    we_c  = avs_byteenable;
                    adv_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (load_c) begin
            addr_q <= avs_address + ADDR_W'(1);
            rem_q  <= len_c - BURST_W'(1);
        end else if (adv_c) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - BURST_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            avs_waitrequest   <= 1'b1;
            rd_pipe           <= 1'b0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            err               <= 1'b0;
        end else begin
            avs_waitrequest   <= (next_state == RD) || (next_state == RD_DRAIN);
            rd_pipe           <= issue_c;
            avs_readdatavalid <= rd_pipe;
            if (rd_pipe) begin
                avs_readdata <= ram_q;
            end
            if (err_set_c) begin
                err <= 1'b1;
            end
        end
    end

    sector_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_sys (clk_sys),
        .rd      (issue_c),
        .we      (we_c),
        .addr    (ram_addr_c),
        .wdata   (avs_writedata),
        .rdata   (ram_q)
    );

endmodule

// File: tb/tb_sector_buf_slave.sv
// Directed bench for sector_buf_slave: single-op vector table plus burst,
// clamp, read/write-conflict and mid-burst reset sequences.
module tb_sector_buf_slave;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [6:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [4:0]  avs_burstcount;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_mem [16];

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [4:0]  bc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    sector_buf_slave #(
        .ADDR_W    (7),
        .BURST_W   (5),
        .MAX_BURST (16)
    ) dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .err               (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_wait();
        int n = 0;
        while (avs_waitrequest !== 1'b0 && n < 50) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("idle_timeout", 32'(avs_waitrequest), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
    endtask

    task automatic wr_single(input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [4:0] bc);
        idle_wait();
        avs_address = a; avs_write = 1'b1; avs_writedata = d;
        avs_byteenable = be; avs_burstcount = bc;
        @(posedge clk_sys); #1;
        avs_write = 1'b0;
        chk("wr_next_ready", 32'(avs_waitrequest), 32'd0);
    endtask

    task automatic wr_burst(input logic [6:0] a, input int n, input int stall);
        idle_wait();
        avs_address = a; avs_write = 1'b1; avs_writedata = exp_mem[0];
        avs_byteenable = 4'hF; avs_burstcount = 5'(n);
        @(posedge clk_sys); #1;
        for (int i = 1; i < n; i++) begin
            if (i == 2) begin
                avs_write = 1'b0;
                repeat (stall) begin
                    chk("wr_stall_wait", 32'(avs_waitrequest), 32'd0);
                    @(posedge clk_sys); #1;
                end
            end
            avs_write = 1'b1; avs_writedata = exp_mem[i];
            chk("wr_beat_wait", 32'(avs_waitrequest), 32'd0);
            @(posedge clk_sys); #1;
        end
        avs_write = 1'b0;
    endtask

    // Cycle 0 is the accept cycle; checks run on the falling edge of cycles 1..len+2.
    task automatic rd_burst(input string name, input logic [6:0] a, input logic [4:0] bc,
                            input int len, input bit with_wr);
        idle_wait();
        avs_address = a; avs_read = 1'b1; avs_write = with_wr;
        avs_writedata = 32'h0BAD0BAD; avs_byteenable = 4'hF; avs_burstcount = bc;
        @(posedge clk_sys); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        for (int c = 1; c <= len + 2; c++) begin
            @(negedge clk_sys);
            chk({name, "_wait"}, 32'(avs_waitrequest), 32'(c <= len + 1));
            chk({name, "_valid"}, 32'(avs_readdatavalid), 32'(c >= 2 && c <= len + 1));
            if (c >= 2 && c <= len + 1) chk({name, "_data"}, avs_readdata, exp_mem[c-2]);
        end
        @(posedge clk_sys); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0; avs_burstcount = 5'd1;

        vecs[0]  = '{1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 5'd1, 32'h0};
        vecs[1]  = '{1'b0, 7'd5,   32'h0,        4'hF, 5'd1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 7'd9,   32'hFFFFFFFF, 4'hF, 5'd1, 32'h0};
        vecs[3]  = '{1'b1, 7'd9,   32'h00000000, 4'h5, 5'd1, 32'h0};
        vecs[4]  = '{1'b0, 7'd9,   32'h0,        4'hF, 5'd1, 32'hFF00FF00};
        vecs[5]  = '{1'b1, 7'd3,   32'h12345678, 4'hF, 5'd1, 32'h0};
        vecs[6]  = '{1'b1, 7'd3,   32'hAAAAAAAA, 4'h0, 5'd1, 32'h0};
        vecs[7]  = '{1'b0, 7'd3,   32'h0,        4'hF, 5'd1, 32'h12345678};
        vecs[8]  = '{1'b1, 7'd127, 32'h00000000, 4'hF, 5'd1, 32'h0};
        vecs[9]  = '{1'b1, 7'd127, 32'hCAFEF00D, 4'h8, 5'd1, 32'h0};
        vecs[10] = '{1'b0, 7'd127, 32'h0,        4'hF, 5'd1, 32'hCA000000};
        vecs[11] = '{1'b1, 7'd20,  32'h11111111, 4'hF, 5'd0, 32'h0};
        vecs[12] = '{1'b0, 7'd20,  32'h0,        4'hF, 5'd0, 32'h11111111};

        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_wait",  32'(avs_waitrequest),   32'd1);
        chk("rst_valid", 32'(avs_readdatavalid), 32'd0);
        chk("rst_rdata", avs_readdata,           32'd0);
        chk("rst_err",   32'(err),               32'd0);
        reset = 1'b0;
        @(posedge clk_sys); #1;
        chk("rst_release_wait", 32'(avs_waitrequest), 32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                wr_single(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].bc);
            end else begin
                exp_mem[0] = vecs[i].exp;
                rd_burst("vec_rd", vecs[i].addr, vecs[i].bc, 1, 1'b0);
            end
        end
        chk("vec_err", 32'(err), 32'd0);

        // Wrapping write burst with a 3-cycle master stall, read back.
        for (int i = 0; i < 4; i++) exp_mem[i] = 32'(i + 1);
        wr_burst(7'd126, 4, 3);
        rd_burst("wrap_rd", 7'd126, 5'd4, 4, 1'b0);
        chk("wrap_err", 32'(err), 32'd0);

        // Read and write together: read wins with old data, write dropped.
        exp_mem[0] = 32'h12345678;
        rd_burst("rw_rd", 7'd3, 5'd1, 1, 1'b1);
        chk("rw_err", 32'(err), 32'd1);
        rd_burst("rw_after", 7'd3, 5'd1, 1, 1'b0);
        chk("rw_err_sticky", 32'(err), 32'd1);

        do_reset();
        chk("err_cleared", 32'(err), 32'd0);

        // Oversize burstcount clamps to 16 beats and flags err.
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h01010101 * 32'(i) + 32'h100;
        wr_burst(7'd0, 16, 0);
        chk("fill_err", 32'(err), 32'd0);
        rd_burst("clamp_rd", 7'd0, 5'd20, 16, 1'b0);
        chk("clamp_err", 32'(err), 32'd1);
        repeat (5) @(posedge clk_sys);
        #1;
        chk("clamp_err_sticky", 32'(err), 32'd1);

        // Reset during cycle 3 of an 8-beat read.
        do_reset();
        idle_wait();
        avs_address = 7'd0; avs_read = 1'b1; avs_burstcount = 5'd8;
        @(posedge clk_sys); #1;
        avs_read = 1'b0;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("mid_valid_c3", 32'(avs_readdatavalid), 32'd1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        chk("mid_valid_c4", 32'(avs_readdatavalid), 32'd0);
        chk("mid_wait_c4",  32'(avs_waitrequest),   32'd1);
        @(posedge clk_sys); #1;
        chk("mid_wait_c5",  32'(avs_waitrequest),   32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_valid", 32'(avs_readdatavalid), 32'd0);
            @(posedge clk_sys); #1;
        end
        chk("mid_err", 32'(err), 32'd0);
        exp_mem[0] = 32'h02020302;
        rd_burst("post_rst", 7'd2, 5'd1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
